// File: rtl/ysyx_22050550_fwd_unit.sv
// Operand forwarding and hazard unit: per-port bypass from EX/MEM/WB/history,
// load-use stall detection, and saturating stall statistics.
module ysyx_22050550_fwd_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned HIST_EN = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [NREAD*5-1:0]    id_raddr,
  input  logic                  ex_valid,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [4:0]            ex_waddr,
  input  logic [XLEN-1:0]       ex_wdata,
  input  logic                  mem_valid,
  input  logic                  mem_wen,
  input  logic                  mem_is_load,
  input  logic                  mem_ready,
  input  logic [4:0]            mem_waddr,
  input  logic [XLEN-1:0]       mem_wdata,
  input  logic                  wb_valid,
  input  logic                  wb_wen,
  input  logic [4:0]            wb_waddr,
  input  logic [XLEN-1:0]       wb_wdata,
  output logic [NREAD-1:0]      id_pass,
  output logic [NREAD*XLEN-1:0] id_rdata,
  output logic                  id_stall,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      stall_events
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e            state_q, state_d;
  logic              hist_valid_q;
  logic [4:0]        hist_waddr_q;
  logic [XLEN-1:0]   hist_wdata_q;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  stall_events_q, stall_events_d;
  logic              stall_event;

  logic [NREAD-1:0]  hazard;
  logic [4:0]        raddr;
  logic              ex_hit, mem_hit, wb_hit, hist_hit;
  logic [XLEN-1:0]   win_data;
  logic              win_haz;

  // History register keeps the last committed WB write visible for one more cycle.
  if (HIST_EN != 0) begin : g_hist
    logic            hist_valid_d;
    logic [4:0]      hist_waddr_d;
    logic [XLEN-1:0] hist_wdata_d;

    // Next history entry comes straight from WB; flush leaves it alone.
    always_comb begin
      hist_valid_d = wb_valid && wb_wen && (wb_waddr != 5'd0);
      hist_waddr_d = wb_waddr;
      hist_wdata_d = wb_wdata;
    end

    // History state register.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hist_valid_q <= 1'b0;
        hist_waddr_q <= '0;
        hist_wdata_q <= '0;
      end else begin
        hist_valid_q <= hist_valid_d;
        hist_waddr_q <= hist_waddr_d;
        hist_wdata_q <= hist_wdata_d;
      end
    end
  end else begin : g_no_hist
    assign hist_valid_q = 1'b0;
    assign hist_waddr_q = '0;
    assign hist_wdata_q = '0;
  end

  // Per-port producer selection, youngest first; hazard when the winner's data is not ready.
  always_comb begin
    id_pass  = '0;
    id_rdata = '0;
    hazard   = '0;
    raddr    = '0;
    ex_hit   = 1'b0;
    mem_hit  = 1'b0;
    wb_hit   = 1'b0;
    hist_hit = 1'b0;
    win_data = '0;
    win_haz  = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      raddr    = id_raddr[5*k +: 5];
      ex_hit   = ex_valid && ex_wen && (ex_waddr == raddr) && (raddr != 5'd0);
      mem_hit  = mem_valid && mem_wen && (mem_waddr == raddr) && (raddr != 5'd0);
      wb_hit   = wb_valid && wb_wen && (wb_waddr == raddr) && (raddr != 5'd0);
      hist_hit = hist_valid_q && (hist_waddr_q == raddr) && (raddr != 5'd0);
      win_data = '0;
      win_haz  = 1'b0;
      if (ex_hit) begin
        win_data = ex_wdata;
        win_haz  = ex_is_load;
      end else if (mem_hit) begin
        win_data = mem_wdata;
        win_haz  = mem_is_load && !mem_ready;
      end else if (wb_hit) begin
        win_data = wb_wdata;
      end else if (hist_hit) begin
        win_data = hist_wdata_q;
      end
      hazard[k]                  = win_haz;
      id_pass[k]                 = !reset && id_valid && !win_haz &&
                                   (ex_hit || mem_hit || wb_hit || hist_hit);
      id_rdata[k*XLEN +: XLEN]   = reset ? '0 : win_data;
    end
  end

  assign id_stall = id_valid && (|hazard) && !flush && !reset;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:   if (id_stall) state_d = StStall;
        StStall: if (!id_stall) state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // FSM outputs: a stall event is a RUN->STALL entry.
  always_comb begin
    stall_event = (state_q == StRun) && id_stall;
  end

  // Saturating counter next-state.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    stall_events_d = stall_events_q;
    if (id_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (stall_event && (stall_events_q != '1)) stall_events_d = stall_events_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      stall_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      stall_events_q <= stall_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign stall_events = stall_events_q;

endmodule

// File: tb/tb_ysyx_22050550_fwd_unit.sv
// Bench for ysyx_22050550_fwd_unit: combinational vector table plus stall/history/reset sequences.
module tb_ysyx_22050550_fwd_unit;

  logic         clock, reset, flush, id_valid;
  logic [9:0]   id_raddr;
  logic         ex_valid, ex_wen, ex_is_load;
  logic [4:0]   ex_waddr;
  logic [63:0]  ex_wdata;
  logic         mem_valid, mem_wen, mem_is_load, mem_ready;
  logic [4:0]   mem_waddr;
  logic [63:0]  mem_wdata;
  logic         wb_valid, wb_wen;
  logic [4:0]   wb_waddr;
  logic [63:0]  wb_wdata;

  logic [1:0]   pass_a, pass_b, pass_c;
  logic [127:0] rdata_a, rdata_b, rdata_c;
  logic         stall_a, stall_b, stall_c;
  logic [31:0]  cyc_a, evt_a, cyc_b, evt_b;
  logic [3:0]   cyc_c, evt_c;

  int nchk = 0;
  int nerr = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ysyx_22050550_fwd_unit u_dut (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid), .id_raddr(id_raddr),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_valid(wb_valid),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .id_pass(pass_a),
    .id_rdata(rdata_a), .id_stall(stall_a), .stall_cycles(cyc_a), .stall_events(evt_a)
  );

  ysyx_22050550_fwd_unit #(.HIST_EN(0)) u_nohist (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid), .id_raddr(id_raddr),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_valid(wb_valid),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .id_pass(pass_b),
    .id_rdata(rdata_b), .id_stall(stall_b), .stall_cycles(cyc_b), .stall_events(evt_b)
  );

  ysyx_22050550_fwd_unit #(.CNT_W(4)) u_cnt4 (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid), .id_raddr(id_raddr),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_valid(wb_valid),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .id_pass(pass_c),
    .id_rdata(rdata_c), .id_stall(stall_c), .stall_cycles(cyc_c), .stall_events(evt_c)
  );

  typedef struct {
    logic        idv;
    logic [4:0]  ra0, ra1;
    logic        exv, exw, exl;
    logic [4:0]  exa;
    logic [63:0] exd;
    logic        memv, memw, meml, memr;
    logic [4:0]  mema;
    logic [63:0] memd;
    logic        wbv, wbw;
    logic [4:0]  wba;
    logic [63:0] wbd;
    logic [1:0]  pass;
    logic [63:0] r0, r1;
    logic        stall;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; id_valid = 1'b0; id_raddr = '0;
    ex_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
    mem_valid = 1'b0; mem_wen = 1'b0; mem_is_load = 1'b0; mem_ready = 1'b0;
    mem_waddr = '0; mem_wdata = '0;
    wb_valid = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic ex_load7();
    id_valid = 1'b1; id_raddr[9:5] = 5'd7;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd7; ex_wdata = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Reset with a live forwarding hit and a load hazard present: outputs must stay 0.
    id_valid = 1'b1; id_raddr = {5'd7, 5'd5};
    mem_valid = 1'b1; mem_wen = 1'b1; mem_waddr = 5'd5; mem_wdata = 64'h22;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd7;
    #3;
    chk("rst_pass", 0, 64'(pass_a), 64'd0);
    chk("rst_rdata0", 0, rdata_a[63:0], 64'd0);
    chk("rst_stall", 0, 64'(stall_a), 64'd0);
    chk("rst_cycles", 0, 64'(cyc_a), 64'd0);
    chk("rst_events", 0, 64'(evt_a), 64'd0);
    step();
    idle();
    reset = 1'b0;
    step();

    //           idv ra0    ra1    exv exw exl exa    exd         memv memw meml memr mema   memd
    //           wbv wbw wba    wbd          pass   r0           r1           stall
    tv.push_back('{'1, 5'd5, 5'd0, '1, '1, '0, 5'd5, 64'h11, '1, '1, '0, '1, 5'd5, 64'h22,
                   '1, '1, 5'd5, 64'h33, 2'b01, 64'h11, 64'h0, '0});
    tv.push_back('{'1, 5'd5, 5'd0, '0, '0, '0, 5'd0, 64'h0, '1, '1, '0, '1, 5'd5, 64'h22,
                   '1, '1, 5'd5, 64'h33, 2'b01, 64'h22, 64'h0, '0});
    tv.push_back('{'1, 5'd5, 5'd0, '0, '0, '0, 5'd0, 64'h0, '0, '0, '0, '0, 5'd0, 64'h0,
                   '1, '1, 5'd5, 64'h33, 2'b01, 64'h33, 64'h0, '0});
    tv.push_back('{'1, 5'd0, 5'd0, '1, '1, '1, 5'd0, 64'hFF, '1, '1, '0, '1, 5'd0, 64'hEE,
                   '1, '1, 5'd0, 64'hDD, 2'b00, 64'h0, 64'h0, '0});
    tv.push_back('{'1, 5'd0, 5'd7, '1, '1, '1, 5'd7, 64'h0, '0, '0, '0, '0, 5'd0, 64'h0,
                   '0, '0, 5'd0, 64'h0, 2'b00, 64'h0, 64'h0, '1});
    tv.push_back('{'1, 5'd0, 5'd7, '1, '1, '1, 5'd7, 64'h0, '1, '1, '0, '1, 5'd7, 64'h99,
                   '0, '0, 5'd0, 64'h0, 2'b00, 64'h0, 64'h0, '1});
    tv.push_back('{'1, 5'd0, 5'd7, '0, '0, '0, 5'd0, 64'h0, '1, '1, '1, '0, 5'd7, 64'h0,
                   '0, '0, 5'd0, 64'h0, 2'b00, 64'h0, 64'h0, '1});
    tv.push_back('{'1, 5'd0, 5'd7, '0, '0, '0, 5'd0, 64'h0, '1, '1, '1, '1, 5'd7, 64'hABCD,
                   '0, '0, 5'd0, 64'h0, 2'b10, 64'h0, 64'hABCD, '0});
    tv.push_back('{'0, 5'd5, 5'd0, '1, '1, '0, 5'd5, 64'h11, '0, '0, '0, '0, 5'd0, 64'h0,
                   '0, '0, 5'd0, 64'h0, 2'b00, 64'h11, 64'h0, '0});
    tv.push_back('{'0, 5'd0, 5'd7, '1, '1, '1, 5'd7, 64'h0, '0, '0, '0, '0, 5'd0, 64'h0,
                   '0, '0, 5'd0, 64'h0, 2'b00, 64'h0, 64'h0, '0});
    tv.push_back('{'1, 5'd3, 5'd4, '0, '0, '0, 5'd0, 64'h0, '1, '1, '0, '1, 5'd3, 64'h30,
                   '1, '1, 5'd4, 64'h40, 2'b11, 64'h30, 64'h40, '0});
    tv.push_back('{'1, 5'd0, 5'd4, '0, '0, '0, 5'd0, 64'h0, '0, '0, '0, '0, 5'd0, 64'h0,
                   '1, '0, 5'd4, 64'h40, 2'b00, 64'h0, 64'h0, '0});
    tv.push_back('{'1, 5'd5, 5'd0, '0, '1, '0, 5'd5, 64'h11, '1, '1, '0, '1, 5'd5, 64'h22,
                   '0, '0, 5'd0, 64'h0, 2'b01, 64'h22, 64'h0, '0});
    tv.push_back('{'1, 5'd6, 5'd0, '1, '1, '0, 5'd5, 64'h11, '0, '0, '0, '0, 5'd0, 64'h0,
                   '0, '0, 5'd0, 64'h0, 2'b00, 64'h0, 64'h0, '0});
    tv.push_back('{'1, 5'd5, 5'd0, '0, '0, '0, 5'd0, 64'h0, '1, '1, '0, '0, 5'd5, 64'h55,
                   '0, '0, 5'd0, 64'h0, 2'b01, 64'h55, 64'h0, '0});
    tv.push_back('{'1, 5'd7, 5'd8, '1, '1, '1, 5'd7, 64'h0, '1, '1, '0, '1, 5'd8, 64'h88,
                   '0, '0, 5'd0, 64'h0, 2'b10, 64'h0, 64'h88, '1});

    for (int i = 0; i < tv.size(); i++) begin
      id_valid = tv[i].idv; id_raddr = {tv[i].ra1, tv[i].ra0};
      ex_valid = tv[i].exv; ex_wen = tv[i].exw; ex_is_load = tv[i].exl;
      ex_waddr = tv[i].exa; ex_wdata = tv[i].exd;
      mem_valid = tv[i].memv; mem_wen = tv[i].memw; mem_is_load = tv[i].meml;
      mem_ready = tv[i].memr; mem_waddr = tv[i].mema; mem_wdata = tv[i].memd;
      wb_valid = tv[i].wbv; wb_wen = tv[i].wbw; wb_waddr = tv[i].wba; wb_wdata = tv[i].wbd;
      @(negedge clock);
      chk("vec_pass", i, 64'(pass_a), 64'(tv[i].pass));
      chk("vec_rdata0", i, rdata_a[63:0], tv[i].r0);
      chk("vec_rdata1", i, rdata_a[127:64], tv[i].r1);
      chk("vec_stall", i, 64'(stall_a), 64'(tv[i].stall));
      step();
      idle();
      step();
    end

    // Load-use: EX load then MEM load waiting three cycles for data.
    do_reset();
    idle();
    ex_load7();
    @(negedge clock);
    chk("lu_ex_stall", 0, 64'(stall_a), 64'd1);
    chk("lu_ex_pass1", 0, 64'(pass_a[1]), 64'd0);
    step();
    ex_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd7; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("lu_mem_stall", c, 64'(stall_a), 64'd1);
      step();
    end
    mem_ready = 1'b1; mem_wdata = 64'hABCD;
    @(negedge clock);
    chk("lu_done_stall", 0, 64'(stall_a), 64'd0);
    chk("lu_done_pass1", 0, 64'(pass_a[1]), 64'd1);
    chk("lu_done_rdata1", 0, rdata_a[127:64], 64'hABCD);
    step();
    idle();
    chk("lu_cycles", 0, 64'(cyc_a), 64'd4);
    chk("lu_events", 0, 64'(evt_a), 64'd1);

    // History: WB write visible one extra cycle only when HIST_EN=1.
    do_reset();
    idle();
    id_valid = 1'b1; id_raddr[4:0] = 5'd9;
    wb_valid = 1'b1; wb_wen = 1'b1; wb_waddr = 5'd9; wb_wdata = 64'h55;
    @(negedge clock);
    chk("hist_wb_pass0", 0, 64'(pass_a[0]), 64'd1);
    step();
    wb_valid = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    @(negedge clock);
    chk("hist_n1_pass0", 0, 64'(pass_a[0]), 64'd1);
    chk("hist_n1_rdata0", 0, rdata_a[63:0], 64'h55);
    chk("nohist_n1_pass0", 0, 64'(pass_b[0]), 64'd0);
    chk("nohist_n1_rdata0", 0, rdata_b[63:0], 64'd0);
    step();
    @(negedge clock);
    chk("hist_n2_pass0", 0, 64'(pass_a[0]), 64'd0);
    chk("hist_n2_rdata0", 0, rdata_a[63:0], 64'd0);

    // Flush during a stall returns to RUN; a re-stall is a new event.
    do_reset();
    idle();
    ex_load7();
    @(negedge clock);
    chk("fl_stall", 0, 64'(stall_a), 64'd1);
    step();
    flush = 1'b1;
    @(negedge clock);
    chk("fl_flush_stall", 0, 64'(stall_a), 64'd0);
    step();
    chk("fl_cycles", 0, 64'(cyc_a), 64'd1);
    chk("fl_events", 0, 64'(evt_a), 64'd1);
    flush = 1'b0;
    step();
    chk("fl_restall_cycles", 0, 64'(cyc_a), 64'd2);
    chk("fl_restall_events", 0, 64'(evt_a), 64'd2);

    // Asynchronous reset mid-stall, with a live bypass on port 0.
    id_raddr[4:0] = 5'd5;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_waddr = 5'd5; mem_wdata = 64'h22;
    @(negedge clock);
    chk("ar_pre_stall", 0, 64'(stall_a), 64'd1);
    chk("ar_pre_pass", 0, 64'(pass_a), 64'b01);
    #1 reset = 1'b1;
    #1;
    chk("ar_stall", 0, 64'(stall_a), 64'd0);
    chk("ar_pass", 0, 64'(pass_a), 64'd0);
    chk("ar_rdata0", 0, rdata_a[63:0], 64'd0);
    chk("ar_cycles", 0, 64'(cyc_a), 64'd0);
    chk("ar_events", 0, 64'(evt_a), 64'd0);
    step();
    idle();
    reset = 1'b0;
    step();
    chk("ar_post_cycles", 0, 64'(cyc_a), 64'd0);

    // Saturation with a 4-bit counter.
    do_reset();
    idle();
    ex_load7();
    repeat (20) @(posedge clock);
    #1;
    chk("sat4_cycles", 0, 64'(cyc_c), 64'd15);
    chk("sat4_events", 0, 64'(evt_c), 64'd1);
    chk("sat32_cycles", 0, 64'(cyc_a), 64'd20);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
